// File: rtl/traffic_lights_cmd_issuer.sv
// traffic_lights_cmd_issuer: FIFO-buffered host commands replayed as spaced one-cycle strobes.
// Optional synchronous flush port is enabled by defining TL_CMD_ISSUER_FLUSH_EN.
package definitions_pkg;
  typedef enum logic [2:0] {
    CMD_NOP         = 3'd0,
    CMD_RESET       = 3'd1,
    CMD_SET_MODE    = 3'd2,
    CMD_FORCE_RED   = 3'd3,
    CMD_FORCE_FLASH = 3'd4,
    CMD_SET_TIMING  = 3'd5,
    CMD_PED_REQUEST = 3'd6,
    CMD_RESUME      = 3'd7
  } command_e;
endpackage

// state | meaning
// IDLE  | waiting for a buffered command; pops and strobes when non-empty
// ISSUE | strobe cycle; loads gap counter
// GAP   | enforced quiet time between strobes
module traffic_lights_cmd_issuer
  import definitions_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int MIN_GAP_TICKS = 4
) (
  input  logic                             clk_2k_i,
  input  logic                             arst_n_i,
  input  command_e                         host_type_i,
  input  logic [15:0]                      host_data_i,
  input  logic                             host_valid_i,
  output logic                             host_ready_o,
  output command_e                         cmd_type_o,
  output logic [15:0]                      cmd_data_o,
  output logic                             cmd_valid_o,
  output logic                             busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level_o
`ifdef TL_CMD_ISSUER_FLUSH_EN
  ,
  input  logic                             flush_i
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int GW = (MIN_GAP_TICKS > 1) ? $clog2(MIN_GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP_TICKS - 1);
  localparam logic [LW-1:0] DEPTH_L  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_e;

  state_e         state;
  logic [GW-1:0]  gap_cnt;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  command_e       mem_type [FIFO_DEPTH];
  logic [15:0]    mem_data [FIFO_DEPTH];
  logic           flush;
  logic           push;
  logic           pop;

`ifdef TL_CMD_ISSUER_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Ready depends only on the registered count, so a same-cycle pop never frees a full FIFO.
  assign host_ready_o = (level_o < DEPTH_L) && !flush;
  assign push         = host_valid_i && host_ready_o;
  assign pop          = (state == IDLE) && (level_o != '0);
  assign busy_o       = (level_o != '0) || (state != IDLE);

  always_ff @(posedge clk_2k_i) begin
    if (push) begin
      mem_type[wr_ptr] <= host_type_i;
      mem_data[wr_ptr] <= host_data_i;
    end
  end

  always_ff @(posedge clk_2k_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      cmd_valid_o <= 1'b0;
      cmd_type_o  <= command_e'(0);
      cmd_data_o  <= '0;
    end else if (flush) begin
      // Last issued type/data stay visible; only the queue and sequencing are cleared.
      state       <= IDLE;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      cmd_valid_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   level_o <= level_o + LW'(1);
        2'b01:   level_o <= level_o - LW'(1);
        default: level_o <= level_o;
      endcase

      case (state)
        IDLE: begin
          if (pop) begin
            cmd_type_o  <= mem_type[rd_ptr];
            cmd_data_o  <= mem_data[rd_ptr];
            cmd_valid_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cmd_valid_o <= 1'b0;
          gap_cnt     <= GAP_LOAD;
          state       <= GAP;
        end
        GAP: begin
          if (gap_cnt == '0) state <= IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: begin
          cmd_valid_o <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_lights_cmd_issuer.sv
// Scoreboard bench for traffic_lights_cmd_issuer (FIFO_DEPTH=4, MIN_GAP_TICKS=4).
// Flush scenario is compiled in only when TL_CMD_ISSUER_FLUSH_EN is defined.
module tb_traffic_lights_cmd_issuer;
  import definitions_pkg::*;

  localparam int DEPTH  = 4;
  localparam int GAP    = 4;
  localparam int PERIOD = GAP + 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  command_e    host_type = CMD_NOP;
  logic [15:0] host_data = 16'h0;
  logic        host_valid = 1'b0;
  logic        host_ready;
  command_e    cmd_type;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        busy;
  logic [2:0]  level;
  logic        flush = 1'b0;

  int          total = 0;
  int          bad = 0;
  int          edge_n = 0;
  logic [18:0] exp_q[$];
  int          pulse_q[$];
  logic        saw_full = 1'b0;

  logic        m_prev_valid = 1'b0;
  int          m_last_pulse = -100;
  logic [15:0] m_last_data = 16'h0;
  command_e    m_last_type = CMD_NOP;
  logic [18:0] m_entry;

  traffic_lights_cmd_issuer #(.FIFO_DEPTH(DEPTH), .MIN_GAP_TICKS(GAP)) dut (
    .clk_2k_i     (clk),
    .arst_n_i     (arst_n),
    .host_type_i  (host_type),
    .host_data_i  (host_data),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .cmd_type_o   (cmd_type),
    .cmd_data_o   (cmd_data),
    .cmd_valid_o  (cmd_valid),
    .busy_o       (busy),
    .level_o      (level)
`ifdef TL_CMD_ISSUER_FLUSH_EN
    ,
    .flush_i      (flush)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_cmd(input command_e t, input logic [15:0] d, output int acc_edge);
    int budget;
    budget = 50;
    host_type  = t;
    host_data  = d;
    host_valid = 1'b1;
    while (!host_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("push_timeout", budget > 0, 1);
    @(posedge clk);
    exp_q.push_back({t, d});
    @(negedge clk);
    acc_edge   = edge_n;
    host_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 400;
    while ((busy || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_timeout", budget > 0, 1);
  endtask

  // Monitor: pops the scoreboard on every strobe and checks held outputs otherwise.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!arst_n) begin
        m_prev_valid = 1'b0;
        m_last_pulse = -100;
        m_last_data  = 16'h0;
        m_last_type  = CMD_NOP;
      end
      check("ready_model", host_ready, (level < DEPTH) && !flush);
      check("level_max", level <= DEPTH, 1);
      if (level == DEPTH) saw_full = 1'b1;
      if (cmd_valid) begin
        check("pulse_width", m_prev_valid, 0);
        check("pulse_spacing", (edge_n - m_last_pulse) >= PERIOD, 1);
        check("pulse_has_cmd", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          m_entry = exp_q.pop_front();
          check("cmd_order", {cmd_type, cmd_data}, m_entry);
        end
        pulse_q.push_back(edge_n);
        m_last_pulse = edge_n;
        m_last_type  = cmd_type;
        m_last_data  = cmd_data;
      end else begin
        check("hold_data", cmd_data, m_last_data);
        check("hold_type", cmd_type, m_last_type);
      end
      m_prev_valid = cmd_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d;
    repeat (3) @(negedge clk);
    check("rst_outputs", {cmd_valid, busy, host_ready, level}, 6'b001000);
    check("rst_data", {cmd_type, cmd_data}, 19'h0);
    arst_n = 1'b1;

    repeat (20) begin
      @(negedge clk);
      check("idle_quiet", {cmd_valid, busy, host_ready, level}, 6'b001000);
    end

    // Single command: strobe one edge after acceptance, busy clears 6 edges after.
    pulse_q.delete();
    push_cmd(CMD_SET_MODE, 16'h1234, k);
    check("t2_not_yet", {cmd_valid, level}, 4'b0001);
    @(negedge clk);
    check("t2_strobe", {cmd_valid, cmd_data}, {1'b1, 16'h1234});
    while (edge_n < k + 5) @(negedge clk);
    check("t2_busy_before", busy, 1);
    @(negedge clk);
    check("t2_busy_after", busy, 0);
    check("t2_npulse", pulse_q.size(), 1);
    if (pulse_q.size() > 0) check("t2_pulse_edge", pulse_q[0], k + 1);
    check("t2_data_hold", cmd_data, 16'h1234);

    // Three back-to-back: strobes at k+1, k+7, k+13.
    pulse_q.delete();
    push_cmd(CMD_RESET, 16'd1, k);
    push_cmd(CMD_SET_TIMING, 16'd2, d);
    push_cmd(CMD_RESUME, 16'd3, d);
    wait_idle();
    check("t3_npulse", pulse_q.size(), 3);
    if (pulse_q.size() == 3) begin
      check("t3_edge0", pulse_q[0], k + 1);
      check("t3_edge1", pulse_q[1], k + 7);
      check("t3_edge2", pulse_q[2], k + 13);
    end

    // Eight commands with valid held high: FIFO fills, all issued in order.
    pulse_q.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 8; i++) push_cmd(command_e'(i), 16'hA000 + 16'(i), d);
    wait_idle();
    check("t4_saw_full", saw_full, 1);
    check("t4_npulse", pulse_q.size(), 8);
    check("t4_last_data", cmd_data, 16'hA007);

    // Reset during GAP with two commands buffered.
    pulse_q.delete();
    push_cmd(CMD_FORCE_FLASH, 16'h0101, k);
    push_cmd(CMD_PED_REQUEST, 16'h0202, d);
    push_cmd(CMD_SET_MODE, 16'h0303, d);
    while (edge_n < k + 3) @(negedge clk);
    check("t5_level_pre", level, 2);
    check("t5_busy_pre", busy, 1);
    exp_q.delete();
    pulse_q.delete();
    arst_n = 1'b0;
    #1;
    check("t5_rst_outputs", {cmd_valid, busy, host_ready, level}, 6'b001000);
    check("t5_rst_data", {cmd_type, cmd_data}, 19'h0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_pulse", pulse_q.size(), 0);
    check("t5_idle", {busy, level}, 4'b0000);
    push_cmd(CMD_FORCE_RED, 16'hBEEF, k);
    wait_idle();
    check("t5_npulse", pulse_q.size(), 1);
    if (pulse_q.size() > 0) check("t5_pulse_edge", pulse_q[0], k + 1);

`ifdef TL_CMD_ISSUER_FLUSH_EN
    // Flush with three buffered; a push on the flush edge must be ignored.
    pulse_q.delete();
    push_cmd(CMD_SET_MODE, 16'hC001, k);
    push_cmd(CMD_RESET, 16'hC002, d);
    push_cmd(CMD_RESUME, 16'hC003, d);
    push_cmd(CMD_NOP, 16'hC004, d);
    check("t6_level_pre", level, 3);
    flush = 1'b1;
    host_type  = CMD_FORCE_RED;
    host_data  = 16'hDEAD;
    host_valid = 1'b1;
    @(negedge clk);
    check("t6_level_post", level, 0);
    flush = 1'b0;
    host_valid = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    check("t6_npulse", pulse_q.size(), 1);
    check("t6_data_kept", cmd_data, 16'hC001);
    check("t6_idle", {busy, level}, 4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
